// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: debounced request latch, walk grant on
// the start of pure red, flashing clearance, and abort on loss of pure red.
module ped_crossing_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned WALK_TIME       = 20_000_000,
   parameter int unsigned FLASH_TIME      = 8_000_000,
   parameter int unsigned FLASH_HALF      = 2_000_000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Button,
   input  logic Red,
   input  logic Yellow,
   input  logic Green,
   output logic Walk,
   output logic DontWalk,
   output logic ReqPending,
   output logic WalkDone,
   output logic Conflict
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_WALK,
      S_FLASH
   } state_t;

   localparam logic [31:0] DEB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0] WALK_LAST  = 32'(WALK_TIME - 1);
   localparam logic [31:0] FLASH_LAST = 32'(FLASH_TIME - 1);
   localparam logic [31:0] HALF_LAST  = 32'(FLASH_HALF - 1);

   state_t      state_q, state_d;
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        deb_state_q, deb_state_d;
   logic [31:0] deb_cnt_q, deb_cnt_d;
   logic        press_q, press_d;
   logic        prev_red_only_q, prev_red_only_d;
   logic [31:0] phase_cnt_q, phase_cnt_d;
   logic [31:0] flash_cnt_q, flash_cnt_d;
   logic        flash_phase_q, flash_phase_d;
   logic        walk_done_q, walk_done_d;
   logic        conflict_q, conflict_d;

   logic red_only;
   logic red_start;

   assign red_only  = Red & ~Yellow & ~Green;
   assign red_start = red_only & ~prev_red_only_q;

   // Synchronizer and debounce; press is the accepted rising level change.
   always_comb begin
      sync1_d     = Button;
      sync2_d     = sync1_q;
      deb_state_d = deb_state_q;
      deb_cnt_d   = '0;
      press_d     = 1'b0;
      if (sync2_q != deb_state_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            deb_state_d = sync2_q;
            press_d     = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 32'd1;
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      phase_cnt_d     = phase_cnt_q;
      flash_cnt_d     = flash_cnt_q;
      flash_phase_d   = flash_phase_q;
      walk_done_d     = 1'b0;
      conflict_d      = 1'b0;
      prev_red_only_d = red_only;
      unique case (state_q)
         S_IDLE: begin
            if (press_q) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (red_start) begin
               state_d     = S_WALK;
               phase_cnt_d = '0;
            end
         end
         S_WALK: begin
            if (!red_only) begin
               state_d    = S_IDLE;
               conflict_d = 1'b1;
            end else if (phase_cnt_q == WALK_LAST) begin
               state_d       = S_FLASH;
               phase_cnt_d   = '0;
               flash_cnt_d   = '0;
               flash_phase_d = 1'b0;
            end else begin
               phase_cnt_d = phase_cnt_q + 32'd1;
            end
         end
         S_FLASH: begin
            if (!red_only) begin
               state_d    = S_IDLE;
               conflict_d = 1'b1;
            end else if (phase_cnt_q == FLASH_LAST) begin
               state_d     = S_IDLE;
               walk_done_d = 1'b1;
            end else begin
               phase_cnt_d = phase_cnt_q + 32'd1;
               if (flash_cnt_q == HALF_LAST) begin
                  flash_cnt_d   = '0;
                  flash_phase_d = ~flash_phase_q;
               end else begin
                  flash_cnt_d = flash_cnt_q + 32'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      Walk       = 1'b0;
      DontWalk   = 1'b1;
      ReqPending = 1'b0;
      unique case (state_q)
         S_IDLE:  ;
         S_WAIT:  ReqPending = 1'b1;
         S_WALK: begin
            Walk     = 1'b1;
            DontWalk = 1'b0;
         end
         S_FLASH: DontWalk = flash_phase_q;
         default: ;
      endcase
   end

   assign WalkDone = walk_done_q;
   assign Conflict = conflict_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q         <= S_IDLE;
         sync1_q         <= 1'b0;
         sync2_q         <= 1'b0;
         deb_state_q     <= 1'b0;
         deb_cnt_q       <= '0;
         press_q         <= 1'b0;
         prev_red_only_q <= 1'b1;
         phase_cnt_q     <= '0;
         flash_cnt_q     <= '0;
         flash_phase_q   <= 1'b0;
         walk_done_q     <= 1'b0;
         conflict_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         sync1_q         <= sync1_d;
         sync2_q         <= sync2_d;
         deb_state_q     <= deb_state_d;
         deb_cnt_q       <= deb_cnt_d;
         press_q         <= press_d;
         prev_red_only_q <= prev_red_only_d;
         phase_cnt_q     <= phase_cnt_d;
         flash_cnt_q     <= flash_cnt_d;
         flash_phase_q   <= flash_phase_d;
         walk_done_q     <= walk_done_d;
         conflict_q      <= conflict_d;
      end
   end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl with short timing parameters.
module tb_ped_crossing_ctrl;

   logic Clock = 1'b0;
   logic Reset, Button, Red, Yellow, Green;
   logic Walk, DontWalk, ReqPending, WalkDone, Conflict;

   int vectors = 0;
   int miscompares = 0;

   ped_crossing_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .WALK_TIME(10),
      .FLASH_TIME(8),
      .FLASH_HALF(2)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .Button(Button),
      .Red(Red),
      .Yellow(Yellow),
      .Green(Green),
      .Walk(Walk),
      .DontWalk(DontWalk),
      .ReqPending(ReqPending),
      .WalkDone(WalkDone),
      .Conflict(Conflict)
   );

   always #5 Clock = ~Clock;

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic set_green();
      Red = 1'b0; Yellow = 1'b0; Green = 1'b1;
   endtask

   task automatic set_red();
      Red = 1'b1; Yellow = 1'b0; Green = 1'b0;
   endtask

   task automatic press_req();
      Button = 1'b1;
      repeat (8) step();
      Button = 1'b0;
      repeat (8) step();
   endtask

   task automatic test_reset();
      Reset = 1'b1; Button = 1'b0;
      set_green();
      repeat (2) step();
      vectors++;
      if ({Walk, DontWalk, ReqPending, WalkDone, Conflict} !== 5'b01000) begin
         miscompares++;
         $display("FAIL reset_outs got %b exp 01000",
                  {Walk, DontWalk, ReqPending, WalkDone, Conflict});
      end
      Reset = 1'b0;
      step();
   endtask

   task automatic test_bounce();
      logic [7:0] bounce;
      bounce = 8'b0011_0011;
      for (int i = 0; i < 8; i++) begin
         Button = bounce[i];
         step();
         vectors++;
         if (ReqPending !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_req[%0d] got %b exp 0", i, ReqPending);
         end
      end
      Button = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         step();
         vectors++;
         if (ReqPending !== (i == 6)) begin
            miscompares++;
            $display("FAIL press_lat[%0d] got %b exp %b", i, ReqPending, i == 6);
         end
      end
      Button = 1'b0;
      repeat (8) step();
   endtask

   task automatic test_walk_cycle();
      logic [7:0] pat;
      pat = 8'b1100_1100;
      set_red();
      for (int i = 0; i < 10; i++) begin
         step();
         vectors++;
         if ({Walk, DontWalk} !== 2'b10) begin
            miscompares++;
            $display("FAIL walk_on[%0d] got %b exp 10", i, {Walk, DontWalk});
         end
      end
      for (int i = 0; i < 8; i++) begin
         step();
         vectors++;
         if ({Walk, DontWalk} !== {1'b0, pat[i]}) begin
            miscompares++;
            $display("FAIL flash[%0d] got %b exp %b", i, {Walk, DontWalk},
                     {1'b0, pat[i]});
         end
      end
      step();
      vectors++;
      if ({Walk, DontWalk, ReqPending, WalkDone, Conflict} !== 5'b01010) begin
         miscompares++;
         $display("FAIL walk_done got %b exp 01010",
                  {Walk, DontWalk, ReqPending, WalkDone, Conflict});
      end
      step();
      vectors++;
      if (WalkDone !== 1'b0) begin
         miscompares++;
         $display("FAIL done_pulse got %b exp 0", WalkDone);
      end
   endtask

   task automatic test_press_mid_red();
      press_req();
      for (int i = 0; i < 20; i++) begin
         step();
         vectors++;
         if ({Walk, ReqPending} !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_red_wait[%0d] got %b exp 01", i, {Walk, ReqPending});
         end
      end
      set_green();
      repeat (3) step();
      set_red();
      step();
      vectors++;
      if ({Walk, ReqPending} !== 2'b10) begin
         miscompares++;
         $display("FAIL mid_red_start got %b exp 10", {Walk, ReqPending});
      end
      repeat (18) step();
      vectors++;
      if (WalkDone !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_red_done got %b exp 1", WalkDone);
      end
   endtask

   task automatic test_conflict();
      set_green();
      press_req();
      set_red();
      step();
      repeat (5) step();
      Yellow = 1'b1;
      step();
      vectors++;
      if ({Walk, DontWalk, WalkDone, Conflict} !== 4'b0101) begin
         miscompares++;
         $display("FAIL conflict got %b exp 0101", {Walk, DontWalk, WalkDone, Conflict});
      end
      step();
      vectors++;
      if ({Walk, DontWalk, WalkDone, Conflict} !== 4'b0100) begin
         miscompares++;
         $display("FAIL conflict_pulse got %b exp 0100",
                  {Walk, DontWalk, WalkDone, Conflict});
      end
      Yellow = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_flash();
      set_green();
      press_req();
      set_red();
      step();
      repeat (11) step();
      vectors++;
      if (Walk !== 1'b0) begin
         miscompares++;
         $display("FAIL in_flash got %b exp 0", Walk);
      end
      Button = 1'b1;
      Reset = 1'b1;
      step();
      vectors++;
      if ({Walk, DontWalk, ReqPending, WalkDone, Conflict} !== 5'b01000) begin
         miscompares++;
         $display("FAIL mid_reset got %b exp 01000",
                  {Walk, DontWalk, ReqPending, WalkDone, Conflict});
      end
      Reset = 1'b0;
      for (int i = 0; i <= 6; i++) begin
         step();
         vectors++;
         if (ReqPending !== (i == 6)) begin
            miscompares++;
            $display("FAIL held_req[%0d] got %b exp %b", i, ReqPending, i == 6);
         end
      end
      Button = 1'b0;
      repeat (8) step();
      set_green();
      repeat (2) step();
      set_red();
      step();
      vectors++;
      if (Walk !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_walk got %b exp 1", Walk);
      end
      repeat (18) step();
      vectors++;
      if (WalkDone !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_done got %b exp 1", WalkDone);
      end
   endtask

   task automatic test_back_to_back();
      set_green();
      press_req();
      set_red();
      step();
      repeat (2) step();
      Button = 1'b1;
      repeat (8) step();
      Button = 1'b0;
      repeat (8) step();
      vectors++;
      if ({WalkDone, ReqPending} !== 2'b10) begin
         miscompares++;
         $display("FAIL b2b_done got %b exp 10", {WalkDone, ReqPending});
      end
      step();
      set_green();
      repeat (2) step();
      set_red();
      for (int i = 0; i < 4; i++) begin
         step();
         vectors++;
         if ({Walk, DontWalk, ReqPending} !== 3'b010) begin
            miscompares++;
            $display("FAIL b2b_idle[%0d] got %b exp 010", i,
                     {Walk, DontWalk, ReqPending});
         end
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_walk_cycle();
      test_press_mid_red();
      test_conflict();
      test_reset_mid_flash();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
